// File: rtl/register_file.sv
// register_file: multi-entry register file with load/inc/dec ops, two registered write-first read ports and a zero flag.
module register_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_op,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [WIDTH-1:0]  or_rdata_a,
  output logic [WIDTH-1:0]  or_rdata_b,
  output logic              or_zero
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] cur, nxt, rd_a, rd_b;
  logic w_ok, ra_ok, rb_ok, we;
  always_comb begin
    w_ok  = {1'b0, i_waddr} < DEPTH_L;
    ra_ok = {1'b0, i_raddr_a} < DEPTH_L;
    rb_ok = {1'b0, i_raddr_b} < DEPTH_L;
    we    = w_ok && i_op != 2'b00;
    cur   = w_ok ? mem[i_waddr] : '0;
    nxt   = i_op == 2'b01 ? i_wdata : i_op == 2'b10 ? cur + WIDTH'(1) : cur - WIDTH'(1);
    // write-first: a read hitting the entry being modified sees the new value
    rd_a  = !ra_ok ? '0 : (we && i_raddr_a == i_waddr) ? nxt : mem[i_raddr_a];
    rd_b  = !rb_ok ? '0 : (we && i_raddr_b == i_waddr) ? nxt : mem[i_raddr_b];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      or_rdata_a <= '0;
      or_rdata_b <= '0;
      or_zero    <= 1'b0;
    end else begin
      if (we) begin
        mem[i_waddr] <= nxt;
        or_zero      <= nxt == '0;
      end
      or_rdata_a <= rd_a;
      or_rdata_b <= rd_b;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table, corner sequences and randomized run against an array model.
module tb_register_file;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op, op6;
  logic [2:0] wa, ra, rb, wa6, ra6, rb6;
  logic [7:0] wd, wd6, a, b, a6, b6;
  logic       z, z6;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  register_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_waddr(wa), .i_wdata(wd),
    .i_raddr_a(ra), .i_raddr_b(rb), .or_rdata_a(a), .or_rdata_b(b), .or_zero(z));

  register_file #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_op(op6), .i_waddr(wa6), .i_wdata(wd6),
    .i_raddr_a(ra6), .i_raddr_b(rb6), .or_rdata_a(a6), .or_rdata_b(b6), .or_zero(z6));

  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra, rb;
    logic [7:0] ea, eb;
    logic       ez;
  } vec_t;
  vec_t vec [12];

  int unsigned m [8];
  int unsigned mz, nv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    vec[0]  = '{1'b1, 2'b01, 3'd3, 8'hA5, 3'd3, 3'd3, 8'hA5, 8'hA5, 1'b0};
    vec[1]  = '{1'b0, 2'b00, 3'd0, 8'h00, 3'd3, 3'd3, 8'h00, 8'h00, 1'b0};
    vec[2]  = '{1'b1, 2'b00, 3'd0, 8'h00, 3'd3, 3'd3, 8'h00, 8'h00, 1'b0};
    vec[3]  = '{1'b1, 2'b01, 3'd2, 8'h3C, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vec[4]  = '{1'b1, 2'b00, 3'd0, 8'h00, 3'd2, 3'd2, 8'h3C, 8'h3C, 1'b0};
    vec[5]  = '{1'b1, 2'b00, 3'd0, 8'h00, 3'd5, 3'd2, 8'h00, 8'h3C, 1'b0};
    vec[6]  = '{1'b1, 2'b01, 3'd1, 8'hFF, 3'd1, 3'd2, 8'hFF, 8'h3C, 1'b0};
    vec[7]  = '{1'b1, 2'b10, 3'd1, 8'h5A, 3'd1, 3'd2, 8'h00, 8'h3C, 1'b1};
    vec[8]  = '{1'b1, 2'b00, 3'd1, 8'h00, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1};
    vec[9]  = '{1'b1, 2'b11, 3'd1, 8'hAB, 3'd1, 3'd3, 8'hFF, 8'h00, 1'b0};
    vec[10] = '{1'b1, 2'b01, 3'd4, 8'h77, 3'd4, 3'd6, 8'h77, 8'h00, 1'b0};
    vec[11] = '{1'b1, 2'b01, 3'd5, 8'h00, 3'd5, 3'd4, 8'h00, 8'h77, 1'b1};

    rst = 1'b0; op = 2'b00; wa = '0; wd = '0; ra = '0; rb = '0;
    op6 = 2'b00; wa6 = '0; wd6 = '0; ra6 = '0; rb6 = '0;
    #2;
    tick();
    check("reset a", a, 0);
    check("reset b", b, 0);
    check("reset z", z, 0);
    check("reset6 a", a6, 0);
    check("reset6 z", z6, 0);

    for (int i = 0; i < 12; i++) begin
      rst = vec[i].rst; op = vec[i].op; wa = vec[i].wa; wd = vec[i].wd;
      ra = vec[i].ra; rb = vec[i].rb;
      tick();
      check($sformatf("vec%0d a", i), a, vec[i].ea);
      check($sformatf("vec%0d b", i), b, vec[i].eb);
      check($sformatf("vec%0d z", i), z, vec[i].ez);
    end

    // counting loop from a fresh reset
    rst = 1'b0; op = 2'b00;
    tick();
    rst = 1'b1; op = 2'b10; wa = 3'd0; ra = 3'd0; rb = 3'd0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("count%0d", i), a, i);
    end
    op = 2'b00;

    // DEPTH=6: out-of-range writes/reads and reset priority
    op6 = 2'b01; wa6 = 3'd2; wd6 = 8'h00; ra6 = 3'd2; rb6 = 3'd2;
    tick();
    check("d6 zero load", z6, 1);
    op6 = 2'b01; wa6 = 3'd7; wd6 = 8'h11; ra6 = 3'd7; rb6 = 3'd2;
    tick();
    check("d6 oor read7", a6, 0);
    check("d6 oor z hold", z6, 1);
    op6 = 2'b10; wa6 = 3'd6; ra6 = 3'd6; rb6 = 3'd7;
    tick();
    check("d6 oor read6", a6, 0);
    check("d6 oor inc z hold", z6, 1);
    op6 = 2'b00;
    for (int i = 0; i < 6; i++) begin
      ra6 = 3'(i); rb6 = 3'(i);
      tick();
      check($sformatf("d6 entry%0d", i), a6, 0);
    end
    op6 = 2'b01; wa6 = 3'd3; wd6 = 8'h22; ra6 = 3'd3;
    tick();
    check("d6 load a", a6, 8'h22);
    check("d6 load z", z6, 0);
    rst = 1'b0; op6 = 2'b01; wa6 = 3'd3; wd6 = 8'h33;
    tick();
    check("d6 rst prio a", a6, 0);
    rst = 1'b1; op6 = 2'b00;
    tick();
    check("d6 after rst a", a6, 0);
    check("d6 after rst z", z6, 0);

    // randomized run against an arithmetic model
    rst = 1'b0; op = 2'b00;
    tick();
    for (int i = 0; i < 8; i++) m[i] = 0;
    mz = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 19) != 0);
      op = 2'($urandom);
      wa = 3'($urandom);
      ra = 3'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom);
      case ($urandom_range(0, 3))
        0: wd = 8'h00;
        1: wd = 8'hFF;
        default: wd = 8'($urandom);
      endcase
      if (!rst) begin
        for (int i = 0; i < 8; i++) m[i] = 0;
        mz = 0;
      end else if (op != 2'b00) begin
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (m[wa] + 1) % 256 : (m[wa] + 255) % 256;
        m[wa] = nv;
        mz = (nv == 0) ? 1 : 0;
      end
      tick();
      check("rand a", a, rst ? m[ra] : 0);
      check("rand b", b, rst ? m[rb] : 0);
      check("rand z", z, mz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, data width in bits of every entry, legal range 1..32.
REQ-002 The module SHALL have parameter DEPTH, default 8, number of entries, legal range 2..2^ADDR_W.
REQ-003 The module SHALL have parameter ADDR_W, default 3, address width in bits of every address port.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-low; sampled on rising edge of i_clk.
REQ-006 i_op  input  2  operation on entry i_waddr: 00 hold, 01 load i_wdata, 10 increment, 11 decrement.
REQ-007 i_waddr  input  ADDR_W  write/modify address.
REQ-008 i_wdata  input  WIDTH  load data, used only when i_op=01.
REQ-009 i_raddr_a  input  ADDR_W  read address, port A.
REQ-010 i_raddr_b  input  ADDR_W  read address, port B.
REQ-011 or_rdata_a  output  WIDTH  registered read data, port A.
REQ-012 or_rdata_b  output  WIDTH  registered read data, port B.
REQ-013 or_zero  output  1  registered flag, 1 when the value written by the current cycle's op equals zero.

Function
REQ-014 Storage SHALL be DEPTH entries of WIDTH bits, updated only on rising i_clk edges.
REQ-015 i_op=00: no entry SHALL change; or_zero SHALL hold its previous value.
REQ-016 i_op=01: entry i_waddr SHALL take i_wdata at the edge.
REQ-017 i_op=10: entry i_waddr SHALL take (entry+1) mod 2^WIDTH; all-ones wraps to 0.
REQ-018 i_op=11: entry i_waddr SHALL take (entry-1) mod 2^WIDTH; 0 wraps to all-ones.
REQ-019 For i_op!=00, or_zero SHALL register 1 if the new entry value is 0, else 0.
REQ-020 Exactly one entry SHALL be modified per cycle at most; all others SHALL hold.
REQ-021 Reads SHALL have one-cycle latency: or_rdata_x after edge N SHALL reflect i_raddr_x sampled at edge N.
REQ-022 Read-during-write, same address, SHALL be write-first: or_rdata_x SHALL show the new value produced by the op at that edge.
REQ-023 Both read ports SHALL be independent; equal addresses on A and B SHALL return identical data.
REQ-024 Write/modify with i_waddr >= DEPTH SHALL change no entry and SHALL leave or_zero unchanged.
REQ-025 Read with i_raddr_x >= DEPTH SHALL return 0 on or_rdata_x.
REQ-026 i_wdata SHALL be ignored for i_op 00, 10, 11.

Reset
REQ-027 When i_rst=0 at a rising edge, every entry, or_rdata_a, or_rdata_b and or_zero SHALL become 0 at that edge.
REQ-028 Reset SHALL take priority over any i_op; a concurrent load/increment/decrement SHALL be discarded.
REQ-029 Asserting reset mid-sequence SHALL leave no residue: first read after release returns 0 for every address.
REQ-030 No output SHALL change between clock edges in response to i_rst alone.

Verification
REQ-031 Reset: WIDTH=8, DEPTH=8; load 0xA5 to addr 3, pulse i_rst=0 one edge, read addr 3 -> or_rdata_a=0x00, or_zero=0.
REQ-032 Load/read: load 0x3C to addr 2, next cycle read A=2, B=2 -> both 0x3C one cycle later; addr 5 reads 0x00.
REQ-033 Wrap: load 0xFF to addr 1, op=10 on addr 1 -> entry 0x00, or_zero=1; op=11 on addr 1 -> entry 0xFF, or_zero=0.
REQ-034 Bypass: same edge op=01 addr 4 data 0x77 with i_raddr_a=4 -> or_rdata_a=0x77 after that edge; i_raddr_b=6 unaffected.
REQ-035 Counting loop: after reset, 10 consecutive op=10 on addr 0 with i_raddr_a=0 -> or_rdata_a steps 1..10, one per cycle.
REQ-036 Range/priority: DEPTH=6, op=01 addr 7 data 0x11 -> no entry changes, read addr 7 = 0x00; op=01 with i_rst=0 same edge -> entry stays 0x00.
